pll_phase_ctrl: RTL and testbench
=================================

# pll_phase_ctrl

Lock supervisor and dynamic phase-shift sequencer for one ECP5 EHXPLLL instance. It runs on the PLL reference clock and synchronises the asynchronous PLL lock output. It releases a downstream reset only after lock has been stable for a set time. It accepts phase-shift commands over a valid/ready handshake and drives the PLL's dynamic phase ports (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG) with correct setup, pulse and settle spacing.

## Interface
Parameters:
- LOCK_STABLE, 1024: synchronised-lock-high cycles required before release.
- SETUP_CYC, 2: cycles phasesel/phasedir are held before the step pulse.
- PULSE_CYC, 4: cycles phasestep is held low per step.
- SETTLE_CYC, 16: cycles after the phasestep rising edge before the next step.
- PHASE_MOD, 96: phase positions per output (8 × output divider); position counters wrap modulo this value.
- PHASE_W, 8: width of each position counter.

Ports:
- clock  in  1  PLL reference clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  raw PLL LOCK, asynchronous to clock.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid && ready.
- cmd_sel  in  2  output to shift (0=CLKOP … 3=CLKOS3).
- cmd_dir  in  1  1 = delay (+1 per step), 0 = advance (−1 per step).
- cmd_count  in  4  number of steps, 0–15.
- cmd_done  out  1  one-cycle pulse when a command completes.
- phasesel  out  2  to PLL PHASESEL[1:0].
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP; idles high, rising edge applies one step.
- phaseloadreg  out  1  to PLL PHASELOADREG; constant 1.
- lock_stable  out  1  stable-lock indicator.
- domain_rst_n  out  1  active-low reset for PLL-clocked logic.
- phase_pos  out  4*PHASE_W  per-output position; output i is at bits [i*PHASE_W +: PHASE_W].

## Operation
- Lock synchronisation: two-flop synchroniser on pll_locked produces lk_s.
- FSM states:
  - LOCK_WAIT: stability counter counts up while lk_s=1 and clears to 0 whenever lk_s=0. When the count reaches LOCK_STABLE−1 with lk_s=1, go to IDLE.
  - IDLE: cmd_ready=1. On handshake, latch sel/dir/count.
    - count=0: no phase-port activity; pulse cmd_done next cycle; stay in IDLE.
    - count>0: drive phasesel/phasedir from the latched values and go to SETUP.
  - SETUP: hold for SETUP_CYC cycles, then go to PULSE.
  - PULSE: phasestep=0 for PULSE_CYC cycles. On exit phasestep returns to 1; that rising edge is the applied step. Update phase_pos[sel] by ±1 modulo PHASE_MOD (PHASE_MOD−1 +1 → 0; 0 −1 → PHASE_MOD−1). Decrement the remaining count. Go to SETTLE.
  - SETTLE: hold for SETTLE_CYC cycles. Then go to SETUP if steps remain; otherwise pulse cmd_done and go to IDLE.
- cmd_ready is 1 only in IDLE. Commands are never queued.
- lock_stable=1 exactly in IDLE, SETUP, PULSE and SETTLE. domain_rst_n is a registered copy of lock_stable.
- Lock loss: lk_s=0 in any non-LOCK_WAIT state sends the FSM to LOCK_WAIT on the next edge. Effects of that transition:
  - phasestep forced to 1;
  - the current command is aborted with no cmd_done;
  - all phase_pos values cleared to 0, because relock restores the default phase;
  - the counter restarts.
- Lock loss takes priority over a simultaneous handshake; the command is not accepted.
- phasedir and phasesel change only on the SETUP entry edge. They are stable throughout SETUP, PULSE and SETTLE.

## Timing
- Values while reset_n=0:
  - FSM in LOCK_WAIT;
  - cmd_ready=0, cmd_done=0;
  - phasesel=0, phasedir=0;
  - phasestep=1, phaseloadreg=1;
  - lock_stable=0, domain_rst_n=0;
  - phase_pos=0, synchroniser=0, counters=0.
- All outputs are registered.
- Release latency after pll_locked rises (steady): 2 sync cycles + LOCK_STABLE cycles give lock_stable=1; domain_rst_n follows 1 cycle later.
- Loss latency: lock_stable=0 within 3 cycles of pll_locked falling; domain_rst_n=0 one cycle after that.
- Per step: SETUP_CYC + PULSE_CYC + SETTLE_CYC cycles.
- A command of N>0 steps takes 1 + N·(SETUP_CYC+PULSE_CYC+SETTLE_CYC) cycles from the handshake edge to the cmd_done pulse.
- A count=0 command gives cmd_done 1 cycle after the handshake.
- cmd_ready returns to 1 the cycle after cmd_done.
- reset_n assertion mid-command returns every output to its reset value immediately (asynchronous).

## Test plan
- Lock release: hold pll_locked=1 from reset release (LOCK_STABLE=16) → lock_stable rises at cycle 18, domain_rst_n at 19, cmd_ready=1.
- Lock glitch: pll_locked low for 3 cycles at count 10 → counter clears; release occurs 16 cycles after lk_s returns high.
- Single step: sel=1, dir=1, count=1 → phasesel=1 and phasedir=1 for 22 cycles; exactly one phasestep low pulse of 4 cycles; phase_pos[1]=1; cmd_done 23 cycles after the handshake.
- Wrap: sel=0, dir=0, count=3 from pos 0 → 3 pulses; phase_pos[0]=93. Then dir=1, count=5 → phase_pos[0]=2.
- Abort: drop pll_locked during the second PULSE of a count=4 command → phasestep=1, no cmd_done, phase_pos all 0, cmd_ready=0 until relock plus LOCK_STABLE.
- count=0 and back-to-back: count=0 → cmd_done next cycle with phasestep constant 1. A second command presented while busy → not accepted until the cycle after cmd_done.

Source files
------------

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: lock supervisor and dynamic phase-shift sequencer for one
// ECP5 EHXPLLL. Runs on the PLL reference clock, qualifies the raw LOCK
// signal, gates a downstream reset, and steps the PLL phase ports one
// command at a time with setup / pulse / settle spacing.
module pll_phase_ctrl #(
  parameter int LOCK_STABLE = 1024,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int PHASE_MOD   = 96,
  parameter int PHASE_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_sel,
  input  logic                   cmd_dir,
  input  logic [3:0]             cmd_count,
  output logic                   cmd_done,
  output logic [1:0]             phasesel,
  output logic                   phasedir,
  output logic                   phasestep,
  output logic                   phaseloadreg,
  output logic                   lock_stable,
  output logic                   domain_rst_n,
  output logic [4*PHASE_W-1:0]   phase_pos
);

  typedef enum logic [2:0] {LOCK_WAIT, IDLE, SETUP, PULSE, SETTLE} state_e;

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC)
                         : ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
  localparam int CYC_W  = $clog2(MAX_CYC + 1);
  localparam int LCNT_W = $clog2(LOCK_STABLE + 1);

  localparam logic [CYC_W-1:0]  SETUP_LAST  = CYC_W'(SETUP_CYC - 1);
  localparam logic [CYC_W-1:0]  PULSE_LAST  = CYC_W'(PULSE_CYC - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [LCNT_W-1:0] LOCK_LAST   = LCNT_W'(LOCK_STABLE - 1);

  // One phase step with wrap-around in [0, PHASE_MOD-1].
  function automatic logic [PHASE_W-1:0] step_pos(input logic [PHASE_W-1:0] cur,
                                                  input logic up);
    logic [PHASE_W-1:0] top;
    top = PHASE_W'(PHASE_MOD - 1);
    if (up) return (cur == top) ? '0 : cur + 1'b1;
    else    return (cur == '0) ? top : cur - 1'b1;
  endfunction

  state_e                  state_q, state_d;
  logic                    lk_meta_q, lk_s_q;
  logic [LCNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [3:0]              rem_q, rem_d;
  logic [1:0]              phasesel_q, phasesel_d;
  logic                    phasedir_q, phasedir_d;
  logic [3:0][PHASE_W-1:0] pos_q, pos_d;
  logic                    done_d;
  logic                    cmd_done_q, cmd_ready_q, phasestep_q;
  logic                    lock_stable_q, domain_rst_n_q;
  logic                    handshake;

  assign handshake = cmd_valid && cmd_ready_q;

  // Next-state logic: lock loss overrides everything, else the sequencer steps.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cyc_d      = cyc_q;
    rem_d      = rem_q;
    phasesel_d = phasesel_q;
    phasedir_d = phasedir_q;
    pos_d      = pos_q;
    done_d     = 1'b0;

    if (state_q != LOCK_WAIT && !lk_s_q) begin
      // Relock restores the default phase, so positions restart at zero.
      state_d    = LOCK_WAIT;
      lock_cnt_d = '0;
      cyc_d      = '0;
      rem_d      = '0;
      pos_d      = '0;
    end else begin
      unique case (state_q)
        LOCK_WAIT: begin
          if (!lk_s_q)                  lock_cnt_d = '0;
          else if (lock_cnt_q == LOCK_LAST) state_d = IDLE;
          else                          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        IDLE: begin
          if (handshake) begin
            if (cmd_count == 4'd0) begin
              done_d = 1'b1;
            end else begin
              phasesel_d = cmd_sel;
              phasedir_d = cmd_dir;
              rem_d      = cmd_count;
              cyc_d      = '0;
              state_d    = SETUP;
            end
          end
        end
        SETUP: begin
          if (cyc_q == SETUP_LAST) begin
            cyc_d   = '0;
            state_d = PULSE;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        PULSE: begin
          if (cyc_q == PULSE_LAST) begin
            // Leaving PULSE raises phasestep: that edge applies the step.
            cyc_d             = '0;
            state_d           = SETTLE;
            rem_d             = rem_q - 4'd1;
            pos_d[phasesel_q] = step_pos(pos_q[phasesel_q], phasedir_q);
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cyc_q == SETTLE_LAST) begin
            cyc_d = '0;
            if (rem_q != 4'd0) begin
              state_d = SETUP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: state_d = LOCK_WAIT;
      endcase
    end
  end

  // State, synchroniser and registered outputs (all derived from next state).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= LOCK_WAIT;
      lk_meta_q      <= 1'b0;
      lk_s_q         <= 1'b0;
      lock_cnt_q     <= '0;
      cyc_q          <= '0;
      rem_q          <= '0;
      phasesel_q     <= '0;
      phasedir_q     <= 1'b0;
      // NOTE: the four position registers are reset like any other state; they are flops, not RAM.
      pos_q          <= '0;
      cmd_done_q     <= 1'b0;
      cmd_ready_q    <= 1'b0;
      phasestep_q    <= 1'b1;
      lock_stable_q  <= 1'b0;
      domain_rst_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lk_meta_q      <= pll_locked;
      lk_s_q         <= lk_meta_q;
      lock_cnt_q     <= lock_cnt_d;
      cyc_q          <= cyc_d;
      rem_q          <= rem_d;
      phasesel_q     <= phasesel_d;
      phasedir_q     <= phasedir_d;
      pos_q          <= pos_d;
      cmd_done_q     <= done_d;
      // Ready stays low through the done cycle so a new command lands one cycle later.
      cmd_ready_q    <= (state_d == IDLE) && !done_d;
      phasestep_q    <= (state_d != PULSE);
      lock_stable_q  <= (state_d != LOCK_WAIT);
      domain_rst_n_q <= lock_stable_q;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign cmd_done     = cmd_done_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b1;
  assign lock_stable  = lock_stable_q;
  assign domain_rst_n = domain_rst_n_q;
  assign phase_pos    = pos_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Testbench for pll_phase_ctrl: directed commands push their expected
// completion cycle and phase positions into a scoreboard; a monitor pops
// and compares whenever cmd_done pulses.
module tb_pll_phase_ctrl;

  localparam int PW       = 8;
  localparam int STEP_CYC = 22;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            pll_locked;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_sel;
  logic            cmd_dir;
  logic [3:0]      cmd_count;
  logic            cmd_done;
  logic [1:0]      phasesel;
  logic            phasedir;
  logic            phasestep;
  logic            phaseloadreg;
  logic            lock_stable;
  logic            domain_rst_n;
  logic [4*PW-1:0] phase_pos;

  typedef struct {
    int          due;
    logic [31:0] pos;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        errors = 0;
  int        checks = 0;
  int        cyc    = 0;
  int        base   = 0;

  pll_phase_ctrl #(
    .LOCK_STABLE(16), .SETUP_CYC(2), .PULSE_CYC(4), .SETTLE_CYC(16),
    .PHASE_MOD(96), .PHASE_W(PW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sel     (cmd_sel),
    .cmd_dir     (cmd_dir),
    .cmd_count   (cmd_count),
    .cmd_done    (cmd_done),
    .phasesel    (phasesel),
    .phasedir    (phasedir),
    .phasestep   (phasestep),
    .phaseloadreg(phaseloadreg),
    .lock_stable (lock_stable),
    .domain_rst_n(domain_rst_n),
    .phase_pos   (phase_pos)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every cmd_done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && cmd_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: cmd_done with empty scoreboard at cycle %0d", cyc);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.due);
        check("done_phase_pos", phase_pos, e.pos);
      end
    end
  end

  task automatic do_reset(input logic lock_level);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    cmd_valid  = 1'b0;
    repeat (3) @(negedge clock);
    pll_locked = lock_level;
    reset_n    = 1'b1;
    base       = cyc;
  endtask

  // Returns cycles since reset release/raise point of the first lock_stable=1 sample.
  task automatic wait_lock(output int rel);
    rel = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (lock_stable) begin
        rel = cyc - base;
        break;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send(input logic [1:0] sel, input logic dir, input logic [3:0] count,
                      input logic [31:0] exp_pos, input bit push, output int hs_edge);
    sb_entry_t e;
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_dir   = dir;
    cmd_count = count;
    hs_edge   = -1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        hs_edge = cyc + 1;
        break;
      end
      @(negedge clock);
    end
    if (hs_edge < 0) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: cmd_ready never rose, got 0 expected 1");
    end else begin
      if (push) begin
        e.due = hs_edge + STEP_CYC * int'(count);
        e.pos = exp_pos;
        sb_q.push_back(e);
      end
      @(negedge clock);
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int rel, e, ea, eb, lows, pulses, first_low;
    bit sel_ok, prev;
    cmd_sel   = '0;
    cmd_dir   = 1'b0;
    cmd_count = '0;

    // Reset values.
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    cmd_valid  = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_phasesel", phasesel, 0);
    check("rst_phasedir", phasedir, 0);
    check("rst_phasestep", phasestep, 1);
    check("rst_phaseloadreg", phaseloadreg, 1);
    check("rst_lock_stable", lock_stable, 0);
    check("rst_domain_rst_n", domain_rst_n, 0);
    check("rst_phase_pos", phase_pos, 0);

    // Lock release with steady lock from reset release.
    do_reset(1'b1);
    wait_lock(rel);
    check("release_cycle", rel, 18);
    check("release_drst_lag", domain_rst_n, 0);
    check("release_ready", cmd_ready, 1);
    @(negedge clock);
    check("release_drst", domain_rst_n, 1);

    // Lock glitch at stability count 10: lk_s back high at edge 17 -> release at 33.
    do_reset(1'b1);
    repeat (12) @(negedge clock);
    pll_locked = 1'b0;
    repeat (3) @(negedge clock);
    pll_locked = 1'b1;
    wait_lock(rel);
    check("glitch_release_cycle", rel, 33);

    // Single step: one 4-cycle low pulse starting 2 cycles after handshake.
    send(2'd1, 1'b1, 4'd1, 32'h0000_0100, 1'b1, e);
    lows = 0; pulses = 0; first_low = -1; sel_ok = 1'b1; prev = 1'b1;
    for (int i = 0; i <= 22; i++) begin
      if (!phasestep) begin
        lows++;
        if (first_low < 0) first_low = cyc - e;
      end
      if (prev && !phasestep) pulses++;
      prev = phasestep;
      if (phasesel != 2'd1 || phasedir != 1'b1) sel_ok = 1'b0;
      @(negedge clock);
    end
    check("step_low_cycles", lows, 4);
    check("step_pulse_count", pulses, 1);
    check("step_low_start", first_low, 2);
    check("step_sel_dir_held", sel_ok, 1);

    // Wrap: 0 - 3 -> 93, then 93 + 5 -> 2.
    send(2'd0, 1'b0, 4'd3, 32'h0000_015D, 1'b1, e);
    send(2'd0, 1'b1, 4'd5, 32'h0000_0102, 1'b1, e);

    // Abort during the second PULSE of a 4-step command.
    send(2'd2, 1'b1, 4'd4, 32'h0, 1'b0, e);
    repeat (24) @(negedge clock);
    check("abort_in_pulse", phasestep, 0);
    pll_locked = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_pos_before", phase_pos, 32'h0001_0102);
    @(negedge clock);
    check("abort_phasestep", phasestep, 1);
    check("abort_lock_stable", lock_stable, 0);
    check("abort_ready", cmd_ready, 0);
    check("abort_pos_cleared", phase_pos, 0);
    @(negedge clock);
    check("abort_drst", domain_rst_n, 0);
    repeat (2) @(negedge clock);
    pll_locked = 1'b1;
    base       = cyc;
    rel        = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        rel = cyc - base;
        break;
      end
    end
    check("relock_ready_cycle", rel, 18);

    // count=0: done in the cycle after handshake, no step activity.
    send(2'd3, 1'b1, 4'd0, 32'h0, 1'b1, e);
    check("zero_phasestep", phasestep, 1);
    check("zero_ready_low", cmd_ready, 0);
    @(negedge clock);
    check("zero_ready_back", cmd_ready, 1);
    check("zero_phasestep_after", phasestep, 1);

    // Back-to-back: second command waits until the cycle after cmd_done.
    send(2'd3, 1'b1, 4'd2, 32'h0200_0000, 1'b1, ea);
    send(2'd3, 1'b0, 4'd1, 32'h0100_0000, 1'b1, eb);
    check("b2b_accept_delay", eb - ea, 46);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 0);

    // Asynchronous reset mid-pulse.
    send(2'd1, 1'b1, 4'd2, 32'h0, 1'b0, e);
    repeat (3) @(negedge clock);
    check("pre_reset_pulse", phasestep, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_phasestep", phasestep, 1);
    check("async_phasesel", phasesel, 0);
    check("async_ready", cmd_ready, 0);
    check("async_lock_stable", lock_stable, 0);
    check("async_drst", domain_rst_n, 0);
    check("async_phase_pos", phase_pos, 0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
